contador_multicanal: RTL and testbench



---
 rtl/contador_pkg.sv | 21 ++
 rtl/contador_multicanal_if.sv | 13 +
 rtl/contador_sat.sv | 38 +++
 rtl/contador_multicanal.sv | 92 +++++++++
 tb/tb_contador_multicanal.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/contador_pkg.sv
// Shared types, default widths and the saturating-increment helper for the
// per-channel packet counter bank.
package contador_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rd_state_e;

    localparam int unsigned N_CH_DEF   = 4;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned DATA_W_DEF = 12;

    // Increment v unless it already holds the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= top) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/contador_multicanal_if.sv
// Read port of the counter bank: request/index in, acknowledge/count out.
interface contador_multicanal_if #(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned CNT_W = 16
);
    logic             req;
    logic [SEL_W-1:0] idx;
    logic             ack;
    logic [CNT_W-1:0] cuenta;

    modport master (output req, output idx, input  ack, input  cuenta);
    modport slave  (input  req, input  idx, output ack, output cuenta);
endinterface

// File: rtl/contador_sat.sv
// One saturating counter with synchronous clear, clear-on-read zeroing and a
// sticky flag that sets once the count reaches all-ones.
module contador_sat
    import contador_pkg::*;
#(
    parameter int unsigned W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         zero,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);

    logic [W-1:0] q_inc_c;

    assign q_inc_c = W'(sat_inc(64'(q), W));

    // zero restarts the count, keeping a same-edge increment as the first word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q   <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            q   <= '0;
            sat <= 1'b0;
        end else if (zero) begin
            q   <= W'(inc);
            sat <= 1'b0;
        end else if (inc) begin
            q <= q_inc_c;
            if (&q_inc_c) sat <= 1'b1;
        end
    end

endmodule

// File: rtl/contador_multicanal.sv
// Per-channel saturating packet counter bank with a saturating grand total and
// a two-state request/acknowledge read port.
module contador_multicanal
    import contador_pkg::*;
#(
    parameter  int unsigned N_CH        = N_CH_DEF,
    parameter  int unsigned CNT_W       = CNT_W_DEF,
    parameter  int unsigned DATA_W      = DATA_W_DEF,
    parameter  int unsigned CLR_ON_READ = 0,
    localparam int unsigned SEL_W       = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_in,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   clr,
    contador_multicanal_if.slave   rd,
    output logic [CNT_W+SEL_W-1:0] cuenta_total,
    output logic [N_CH-1:0]        sat
);

    rd_state_e        state_q;
    rd_state_e        state_d;
    logic             start_c;
    logic [SEL_W-1:0] sel_c;
    logic [CNT_W-1:0] cnt [N_CH];
    logic             unused_data_c;
    logic             unused_tot_sat;

    assign sel_c         = data_in[SEL_W-1:0];
    assign unused_data_c = ^data_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A read starts from IDLE only, so back-to-back reads are two cycles apart.
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd.req) begin
                    state_d = ACK;
                    start_c = 1'b1;
                end
            end
            ACK: state_d = IDLE;
        endcase
    end

    // Snapshot uses the pre-edge count, so a same-edge increment is not seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd.ack    <= 1'b0;
            rd.cuenta <= '0;
        end else begin
            rd.ack <= start_c;
            if (start_c) rd.cuenta <= cnt[rd.idx];
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic inc_c;
        logic zero_c;

        assign inc_c  = valid_in && (sel_c == SEL_W'(c));
        assign zero_c = (CLR_ON_READ != 0) && start_c && (rd.idx == SEL_W'(c));

        contador_sat #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .zero  (zero_c),
            .inc   (inc_c),
            .q     (cnt[c]),
            .sat   (sat[c])
        );
    end

    contador_sat #(.W(CNT_W + SEL_W)) u_total (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .zero  (1'b0),
        .inc   (valid_in),
        .q     (cuenta_total),
        .sat   (unused_tot_sat)
    );

endmodule

// File: tb/tb_contador_multicanal.sv
// Bench for contador_multicanal: two instances (16-bit plain read, 4-bit
// clear-on-read) share stimulus and are checked against an arithmetic model.
module tb_contador_multicanal;

    localparam int N_CH   = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 12;
    localparam int CW_A   = 16;
    localparam int CW_B   = 4;
    localparam int CW  [2] = '{CW_A, CW_B};
    localparam bit COR [2] = '{1'b0, 1'b1};

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              valid_in = 1'b0;
    logic              clr      = 1'b0;
    logic [DATA_W-1:0] data_in  = '0;
    logic              req      = 1'b0;
    logic [SEL_W-1:0]  idx      = '0;

    logic [CW_A+SEL_W-1:0] tot_a;
    logic [CW_B+SEL_W-1:0] tot_b;
    logic [N_CH-1:0]       sat_a;
    logic [N_CH-1:0]       sat_b;

    int n_chk  = 0;
    int n_fail = 0;
    bit en     = 1'b0;

    always #5 clk = ~clk;

    contador_multicanal_if #(.SEL_W(SEL_W), .CNT_W(CW_A)) rd_a ();
    contador_multicanal_if #(.SEL_W(SEL_W), .CNT_W(CW_B)) rd_b ();

    assign rd_a.req = req;
    assign rd_a.idx = idx;
    assign rd_b.req = req;
    assign rd_b.idx = idx;

    contador_multicanal #(.N_CH(N_CH), .CNT_W(CW_A), .DATA_W(DATA_W), .CLR_ON_READ(0)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .clr          (clr),
        .rd           (rd_a),
        .cuenta_total (tot_a),
        .sat          (sat_a)
    );

    contador_multicanal #(.N_CH(N_CH), .CNT_W(CW_B), .DATA_W(DATA_W), .CLR_ON_READ(1)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .clr          (clr),
        .rd           (rd_b),
        .cuenta_total (tot_b),
        .sat          (sat_b)
    );

    function automatic void check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: plain integer counts per channel, clamped at the width's maximum.
    longint m_cnt [2][N_CH];
    longint m_tot [2];
    bit     m_sat [2][N_CH];
    bit     m_ack [2];
    longint m_cue [2];

    always @(posedge clk or negedge reset) begin
        longint mx;
        longint tmx;
        bit     start;
        bit     hit;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                for (int c = 0; c < N_CH; c++) begin
                    m_cnt[i][c] = 0;
                    m_sat[i][c] = 1'b0;
                end
                m_tot[i] = 0;
                m_ack[i] = 1'b0;
                m_cue[i] = 0;
            end else begin
                mx    = (longint'(1) << CW[i]) - 1;
                tmx   = (longint'(1) << (CW[i] + SEL_W)) - 1;
                start = !m_ack[i] && req;
                if (start) m_cue[i] = m_cnt[i][idx];
                m_ack[i] = start;
                if (clr) begin
                    for (int c = 0; c < N_CH; c++) begin
                        m_cnt[i][c] = 0;
                        m_sat[i][c] = 1'b0;
                    end
                    m_tot[i] = 0;
                end else begin
                    for (int c = 0; c < N_CH; c++) begin
                        hit = valid_in && ((int'(data_in) % N_CH) == c);
                        if (COR[i] && start && (int'(idx) == c)) begin
                            m_cnt[i][c] = hit ? 1 : 0;
                            m_sat[i][c] = 1'b0;
                        end else if (hit) begin
                            if (m_cnt[i][c] < mx) m_cnt[i][c] = m_cnt[i][c] + 1;
                            if (m_cnt[i][c] == mx) m_sat[i][c] = 1'b1;
                        end
                    end
                    if (valid_in && m_tot[i] < tmx) m_tot[i] = m_tot[i] + 1;
                end
            end
        end
    end

    function automatic longint msat(input int i);
        longint v = 0;
        for (int c = 0; c < N_CH; c++) if (m_sat[i][c]) v = v | (longint'(1) << c);
        return v;
    endfunction

    always @(negedge clk) begin
        if (en) begin
            check("ack_a",    rd_a.ack,    m_ack[0]);
            check("cuenta_a", rd_a.cuenta, m_cue[0]);
            check("total_a",  tot_a,       m_tot[0]);
            check("sat_a",    sat_a,       msat(0));
            check("ack_b",    rd_b.ack,    m_ack[1]);
            check("cuenta_b", rd_b.cuenta, m_cue[1]);
            check("total_b",  tot_b,       m_tot[1]);
            check("sat_b",    sat_b,       msat(1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic feed(input logic [DATA_W-1:0] d, input int n);
        valid_in = 1'b1;
        data_in  = d;
        repeat (n) tick();
        valid_in = 1'b0;
    endtask

    task automatic do_read(input logic [SEL_W-1:0] ch, output longint ca, output longint cb);
        req = 1'b1;
        idx = ch;
        tick();
        req = 1'b0;
        check("rd_ack_a", rd_a.ack, 1);
        check("rd_ack_b", rd_b.ack, 1);
        ca = rd_a.cuenta;
        cb = rd_b.cuenta;
        tick();
    endtask

    initial begin
        longint ca;
        longint cb;
        bit     pat [4];
        pat = '{1'b0, 1'b1, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        en = 1'b1;
        #2;
        reset = 1'b1;
        check("rst_ack_a", rd_a.ack, 0);
        check("rst_cuenta_a", rd_a.cuenta, 0);
        check("rst_total_b", tot_b, 0);
        check("rst_sat_b", sat_b, 0);

        // Round-robin over the four channels, three times.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < N_CH; c++) begin
                valid_in = 1'b1;
                data_in  = DATA_W'(c);
                tick();
            end
        end
        valid_in = 1'b0;
        check("p1_total_a", tot_a, 12);
        check("p1_total_b", tot_b, 12);
        for (int c = 0; c < N_CH; c++) begin
            do_read(SEL_W'(c), ca, cb);
            check("p1_read_a", ca, 3);
            check("p1_read_b", cb, 3);
        end
        check("p1_sat_a", sat_a, 0);

        // Upper data bits must not affect channel selection.
        feed(12'hFF2, 5);
        do_read(2'd2, ca, cb);
        check("p2_read2_a", ca, 8);
        check("p2_read2_b", cb, 5);
        do_read(2'd0, ca, cb);
        check("p2_read0_a", ca, 3);
        check("p2_read0_b", cb, 0);
        check("p2_total_a", tot_a, 17);

        // Saturation of the 4-bit bank.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        feed(12'h001, 17);
        check("p3_total_a", tot_a, 17);
        check("p3_total_b", tot_b, 17);
        check("p3_sat_a", sat_a, 0);
        check("p3_sat_b", sat_b, 4'b0010);
        do_read(2'd1, ca, cb);
        check("p3_read_a", ca, 17);
        check("p3_read_b", cb, 15);
        check("p3_sat_b_after_read", sat_b, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("p3_clr_total_a", tot_a, 0);
        check("p3_clr_total_b", tot_b, 0);
        do_read(2'd1, ca, cb);
        check("p3_clr_read_a", ca, 0);

        // Read and increment of channel 3 on the same edge.
        feed(12'h003, 7);
        req      = 1'b1;
        idx      = 2'd3;
        valid_in = 1'b1;
        data_in  = 12'h003;
        tick();
        req      = 1'b0;
        valid_in = 1'b0;
        check("p4_ack_a", rd_a.ack, 1);
        check("p4_cuenta_a", rd_a.cuenta, 7);
        check("p4_cuenta_b", rd_b.cuenta, 7);
        tick();
        do_read(2'd3, ca, cb);
        check("p4_after_a", ca, 8);
        check("p4_after_b", cb, 1);

        // req held high: reads every other cycle.
        req = 1'b1;
        idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            check("p5_ack_pattern", rd_a.ack, pat[k]);
            if (k < 3) tick();
        end
        req = 1'b0;
        tick();
        clr      = 1'b1;
        valid_in = 1'b1;
        data_in  = 12'h000;
        tick();
        clr      = 1'b0;
        valid_in = 1'b0;
        check("p5_clr_drop_a", tot_a, 0);
        check("p5_clr_drop_b", tot_b, 0);

        // Reset asserted while the acknowledge is showing.
        feed(12'h002, 3);
        req = 1'b1;
        idx = 2'd2;
        tick();
        req = 1'b0;
        check("p6_ack_before", rd_a.ack, 1);
        #1 reset = 1'b0;
        #1;
        check("p6_ack_a", rd_a.ack, 0);
        check("p6_ack_b", rd_b.ack, 0);
        check("p6_cuenta_a", rd_a.cuenta, 0);
        check("p6_total_a", tot_a, 0);
        check("p6_sat_b", sat_b, 0);
        tick();
        reset = 1'b1;
        do_read(2'd2, ca, cb);
        check("p6_read_a", ca, 0);
        check("p6_read_b", cb, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
